muldiv_seq: RTL and testbench

//   Iterative unsigned multiply/divide unit. Feeds the HI/LO result-register

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 124 ++++++++++++
 tb/tb_muldiv_seq.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake and result bundle for the sequential multiply/divide unit.
// The master issues requests; the slave (muldiv_seq) returns status and HI/LO results.
interface muldiv_seq_if #(
    parameter int n = 4
);
    logic         start;
    logic         op;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [n-1:0] hi;
    logic [n-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring shift-subtract) unit.
// Takes n iterations per operation; done strobes for one cycle when hi/lo are valid.
module muldiv_seq #(
    parameter int n = 4
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_seq_if.slave   bus
);
    localparam int CW = (n > 2) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic           op_q, op_d;
    logic [n-1:0]   opnd_q, opnd_d;
    logic [n-1:0]   acc_q, acc_d;
    logic [n-1:0]   work_q, work_d;
    logic [n-1:0]   hi_q, hi_d;
    logic [n-1:0]   lo_q, lo_d;
    logic           dbz_q, dbz_d;

    logic [n:0]     mulSum;
    logic [n:0]     remShift;
    logic [n-1:0]   quotShift;
    logic [n-1:0]   accNx;
    logic [n-1:0]   workNx;

    // opnd holds the multiplicand or divisor; acc is the upper accumulator or
    // partial remainder; work holds the multiplier or the dividend/quotient.
    always_comb begin
        mulSum    = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : {(n+1){1'b0}});
        remShift  = {acc_q, work_q[n-1]};
        quotShift = {work_q[n-2:0], 1'b0};
        accNx     = mulSum[n:1];
        workNx    = {mulSum[0], work_q[n-1:1]};
        if (op_q) begin
            accNx  = remShift[n-1:0];
            workNx = quotShift;
            if (remShift >= {1'b0, opnd_q}) begin
                accNx  = remShift[n-1:0] - opnd_q;
                workNx = quotShift | {{(n-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        work_d  = work_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    op_d    = bus.op;
                    dbz_d   = 1'b0;
                    count_d = '0;
                    acc_d   = '0;
                    opnd_d  = bus.op ? bus.b : bus.a;
                    work_d  = bus.op ? bus.a : bus.b;
                    state_d = RUN;
                    if (bus.op && (bus.b == '0)) begin
                        hi_d    = bus.a;
                        lo_d    = {n{1'b1}};
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                acc_d   = accNx;
                work_d  = workNx;
                count_d = count_q + 1'b1;
                if (count_q == CW'(n-1)) begin
                    hi_d    = accNx;
                    lo_d    = workNx;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            work_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (n=4): directed cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_seq;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    muldiv_seq_if #(.n(4)) busIf ();

    muldiv_seq #(.n(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: product split into hi/lo, or remainder/quotient, with the
    // divide-by-zero convention hi=a, lo=all ones and zero extra latency.
    task automatic refModel(input logic opIn, input logic [3:0] aIn, input logic [3:0] bIn,
                            output logic [3:0] hiExp, output logic [3:0] loExp,
                            output logic dbzExp, output int latExp);
        int prod;
        if (opIn == 1'b0) begin
            prod   = int'(aIn) * int'(bIn);
            hiExp  = 4'(prod / 16);
            loExp  = 4'(prod % 16);
            dbzExp = 1'b0;
            latExp = 4;
        end else if (bIn == 4'd0) begin
            hiExp  = aIn;
            loExp  = 4'hF;
            dbzExp = 1'b1;
            latExp = 0;
        end else begin
            hiExp  = 4'(int'(aIn) % int'(bIn));
            loExp  = 4'(int'(aIn) / int'(bIn));
            dbzExp = 1'b0;
            latExp = 4;
        end
    endtask

    // Issues one request and waits (bounded) for done; lat counts edges after capture.
    task automatic runOp(input logic opIn, input logic [3:0] aIn, input logic [3:0] bIn,
                         output int lat, output logic gotDone);
        busIf.start = 1'b1;
        busIf.op    = opIn;
        busIf.a     = aIn;
        busIf.b     = bIn;
        @(posedge clk); #1;
        busIf.start = 1'b0;
        lat = 0;
        while (!busIf.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        gotDone = busIf.done;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        busIf.start = 1'b0;
        busIf.op    = 1'b0;
        busIf.a     = 4'd0;
        busIf.b     = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busIf.busy, busIf.done, busIf.div_by_zero, busIf.hi, busIf.lo} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all zero",
                     busIf.busy, busIf.done, busIf.div_by_zero, busIf.hi, busIf.lo);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul_basic();
        int busyCount;
        busIf.start = 1'b1;
        busIf.op    = 1'b0;
        busIf.a     = 4'd3;
        busIf.b     = 4'd3;
        @(posedge clk); #1;
        busIf.start = 1'b0;
        busyCount = 0;
        for (int i = 0; i < 4; i++) begin
            if (busIf.busy === 1'b1 && busIf.done === 1'b0) busyCount++;
            @(posedge clk); #1;
        end
        checks++;
        if (busyCount !== 4) begin
            errors++;
            $display("[TB] FAIL mul3x3_busy: got %0d busy cycles, expected 4", busyCount);
        end
        checks++;
        if ({busIf.done, busIf.busy, busIf.hi, busIf.lo} !== {1'b1, 1'b0, 4'd0, 4'd9}) begin
            errors++;
            $display("[TB] FAIL mul3x3_result: got done=%b busy=%b hi=%h lo=%h, expected done=1 busy=0 hi=0 lo=9",
                     busIf.done, busIf.busy, busIf.hi, busIf.lo);
        end
        // Results must hold after the done strobe while idle.
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busIf.done, busIf.busy, busIf.hi, busIf.lo} !== {1'b0, 1'b0, 4'd0, 4'd9}) begin
            errors++;
            $display("[TB] FAIL mul3x3_hold: got done=%b busy=%b hi=%h lo=%h, expected done=0 busy=0 hi=0 lo=9",
                     busIf.done, busIf.busy, busIf.hi, busIf.lo);
        end
    endtask

    task automatic test_directed();
        logic [8:0] cases [5];
        logic [3:0] hiExp, loExp;
        logic       dbzExp, gotDone;
        int         latExp, lat;
        cases[0] = {1'b0, 4'd15, 4'd15};
        cases[1] = {1'b0, 4'd0,  4'd9};
        cases[2] = {1'b1, 4'd13, 4'd4};
        cases[3] = {1'b1, 4'd9,  4'd0};
        cases[4] = {1'b0, 4'd2,  4'd3};
        for (int i = 0; i < 5; i++) begin
            refModel(cases[i][8], cases[i][7:4], cases[i][3:0], hiExp, loExp, dbzExp, latExp);
            runOp(cases[i][8], cases[i][7:4], cases[i][3:0], lat, gotDone);
            checks++;
            if ({gotDone, busIf.hi, busIf.lo, busIf.div_by_zero} !== {1'b1, hiExp, loExp, dbzExp} || lat !== latExp) begin
                errors++;
                $display("[TB] FAIL directed_%0d: got done=%b hi=%h lo=%h dbz=%b lat=%0d, expected done=1 hi=%h lo=%h dbz=%b lat=%0d",
                         i, gotDone, busIf.hi, busIf.lo, busIf.div_by_zero, lat, hiExp, loExp, dbzExp, latExp);
            end
            if (i == 3) begin
                repeat (2) @(posedge clk);
                #1;
                checks++;
                if (busIf.div_by_zero !== 1'b1 || busIf.done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL dbz_hold: got dbz=%b done=%b, expected dbz=1 done=0",
                             busIf.div_by_zero, busIf.done);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        busIf.start = 1'b1;
        busIf.op    = 1'b0;
        busIf.a     = 4'd3;
        busIf.b     = 4'd3;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({busIf.done, busIf.hi, busIf.lo} !== {1'b1, 4'd0, 4'd9}) begin
            errors++;
            $display("[TB] FAIL b2b_first: got done=%b hi=%h lo=%h, expected done=1 hi=0 lo=9",
                     busIf.done, busIf.hi, busIf.lo);
        end
        busIf.op = 1'b1;
        busIf.a  = 4'd7;
        busIf.b  = 4'd2;
        @(posedge clk); #1;
        busIf.start = 1'b0;
        checks++;
        if ({busIf.busy, busIf.done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL b2b_capture: got busy=%b done=%b, expected busy=1 done=0",
                     busIf.busy, busIf.done);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({busIf.done, busIf.hi, busIf.lo, busIf.div_by_zero} !== {1'b1, 4'd1, 4'd3, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_second: got done=%b hi=%h lo=%h dbz=%b, expected done=1 hi=1 lo=3 dbz=0",
                     busIf.done, busIf.hi, busIf.lo, busIf.div_by_zero);
        end
    endtask

    task automatic test_start_ignored();
        busIf.start = 1'b1;
        busIf.op    = 1'b1;
        busIf.a     = 4'd13;
        busIf.b     = 4'd4;
        @(posedge clk); #1;
        busIf.start = 1'b0;
        @(posedge clk); #1;
        busIf.start = 1'b1;
        busIf.op    = 1'b0;
        busIf.a     = 4'd15;
        busIf.b     = 4'd15;
        @(posedge clk); #1;
        busIf.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busIf.done, busIf.hi, busIf.lo, busIf.div_by_zero} !== {1'b1, 4'd1, 4'd3, 1'b0}) begin
            errors++;
            $display("[TB] FAIL run_start_ignored: got done=%b hi=%h lo=%h dbz=%b, expected done=1 hi=1 lo=3 dbz=0",
                     busIf.done, busIf.hi, busIf.lo, busIf.div_by_zero);
        end
        @(posedge clk); #1;
        checks++;
        if ({busIf.busy, busIf.done} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL run_no_requeue: got busy=%b done=%b, expected busy=0 done=0",
                     busIf.busy, busIf.done);
        end
    endtask

    task automatic test_reset_abort();
        logic sawDone;
        int   lat;
        logic gotDone;
        busIf.start = 1'b1;
        busIf.op    = 1'b1;
        busIf.a     = 4'd13;
        busIf.b     = 4'd4;
        @(posedge clk); #1;
        busIf.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({busIf.busy, busIf.done, busIf.div_by_zero, busIf.hi, busIf.lo} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL abort_reset: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all zero",
                     busIf.busy, busIf.done, busIf.div_by_zero, busIf.hi, busIf.lo);
        end
        @(posedge clk); #1;
        reset   = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (busIf.done !== 1'b0 || busIf.busy !== 1'b0) sawDone = 1'b1;
        end
        checks++;
        if (sawDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got activity after abort, expected none");
        end
        runOp(1'b0, 4'd5, 4'd3, lat, gotDone);
        checks++;
        if ({gotDone, busIf.hi, busIf.lo} !== {1'b1, 4'd0, 4'hF} || lat !== 4) begin
            errors++;
            $display("[TB] FAIL abort_recover: got done=%b hi=%h lo=%h lat=%0d, expected done=1 hi=0 lo=f lat=4",
                     gotDone, busIf.hi, busIf.lo, lat);
        end
    endtask

    task automatic test_random();
        logic       opR, dbzExp, gotDone;
        logic [3:0] aR, bR, hiExp, loExp;
        int         latExp, lat;
        for (int i = 0; i < 40; i++) begin
            opR = 1'($urandom_range(0, 1));
            aR  = 4'($urandom_range(0, 15));
            bR  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            refModel(opR, aR, bR, hiExp, loExp, dbzExp, latExp);
            runOp(opR, aR, bR, lat, gotDone);
            checks++;
            if ({gotDone, busIf.hi, busIf.lo, busIf.div_by_zero} !== {1'b1, hiExp, loExp, dbzExp} || lat !== latExp) begin
                errors++;
                $display("[TB] FAIL random_%0d op=%b a=%0d b=%0d: got done=%b hi=%h lo=%h dbz=%b lat=%0d, expected hi=%h lo=%h dbz=%b lat=%0d",
                         i, opR, aR, bR, gotDone, busIf.hi, busIf.lo, busIf.div_by_zero, lat,
                         hiExp, loExp, dbzExp, latExp);
            end
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mul_basic();
        test_directed();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
